// File: rtl/spi_pixel_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_pixel_master
// Purpose  : Host-side SPI initiator (mode 0) for the accelerator pixel port.
//            Each frame is full duplex: one PIXEL_WIDTH-bit word is shifted
//            out MSB first on spi_sdo_o while one result word is captured
//            from spi_sdi_i. The user side is a word-level valid/ready
//            handshake on the transmit path. The receive path is a
//            one-cycle rx_valid_o pulse with no backpressure.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i        system clock, the only clock
//   reset_i      synchronous active-high reset
//   tx_valid_i   request to send tx_data_i
//   tx_ready_o   master idle, a word can be accepted
//   tx_data_i    word to transmit, MSB first
//   rx_valid_o   one-cycle pulse, rx_data_o was updated
//   rx_data_o    word captured from the slave, held until the next frame
//   busy_o       high from word accept until return to idle
//   spi_cs_o     chip select, active low
//   spi_sck_o    SPI clock, idle low
//   spi_sdo_o    master out, to slave sdi
//   spi_sdi_i    master in, from slave sdo
// ============================================================================
module spi_pixel_master #(
  parameter int PIXEL_WIDTH = 24,
  parameter int CLK_DIV     = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  input  logic [PIXEL_WIDTH-1:0] tx_data_i,
  output logic                   rx_valid_o,
  output logic [PIXEL_WIDTH-1:0] rx_data_o,
  output logic                   busy_o,
  output logic                   spi_cs_o,
  output logic                   spi_sck_o,
  output logic                   spi_sdo_o,
  input  logic                   spi_sdi_i
);

  localparam int HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W  = $clog2(PIXEL_WIDTH + 1);

  localparam logic [HALF_W-1:0] C_HALF_LAST = HALF_W'(CLK_DIV - 1);
  // The bit counter steps on every falling edge. It reaches PIXEL_WIDTH
  // during the low phase of the final pulse, which marks the last low phase.
  localparam logic [BIT_W-1:0]  C_BIT_DONE  = BIT_W'(PIXEL_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t                 state_q;
  logic [HALF_W-1:0]      half_q;
  logic [BIT_W-1:0]       bit_q;
  logic [PIXEL_WIDTH-1:0] tx_q;
  logic [PIXEL_WIDTH-1:0] rx_q;
  logic [PIXEL_WIDTH-1:0] rx_data_q;
  logic                   rx_valid_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   cs_q;
  logic                   sck_q;
  logic                   sdo_q;

  // Next values of the two shift registers and the half-period counter.
  logic [PIXEL_WIDTH-1:0] tx_shift_d;
  logic [PIXEL_WIDTH-1:0] rx_shift_d;
  logic [HALF_W-1:0]      half_inc_d;
  logic                   half_last_d;

  assign tx_shift_d  = {tx_q[PIXEL_WIDTH-2:0], 1'b0};
  assign rx_shift_d  = {rx_q[PIXEL_WIDTH-2:0], spi_sdi_i};
  assign half_inc_d  = half_q + 1'b1;
  assign half_last_d = (half_q == C_HALF_LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      half_q     <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      sdo_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cs_q   <= 1'b1;
          sck_q  <= 1'b0;
          half_q <= '0;
          bit_q  <= '0;
          if (tx_valid_i && ready_q) begin
            // The MSB is already driven during setup so the slave sees it
            // before the first rising edge.
            tx_q    <= tx_data_i;
            sdo_q   <= tx_data_i[PIXEL_WIDTH-1];
            rx_q    <= '0;
            cs_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (half_last_d) begin
            // The first rising edge samples the first slave bit.
            half_q  <= '0;
            sck_q   <= 1'b1;
            rx_q    <= rx_shift_d;
            state_q <= ST_SHIFT;
          end else begin
            half_q <= half_inc_d;
          end
        end

        ST_SHIFT: begin
          if (half_last_d) begin
            half_q <= '0;
            if (sck_q) begin
              // Falling edge: advance the transmit word.
              sck_q <= 1'b0;
              tx_q  <= tx_shift_d;
              sdo_q <= tx_shift_d[PIXEL_WIDTH-1];
              bit_q <= bit_q + 1'b1;
            end else if (bit_q == C_BIT_DONE) begin
              // The low phase of the final pulse is over.
              sdo_q   <= 1'b0;
              state_q <= ST_HOLD;
            end else begin
              // Rising edge: capture the next slave bit.
              sck_q <= 1'b1;
              rx_q  <= rx_shift_d;
            end
          end else begin
            half_q <= half_inc_d;
          end
        end

        ST_HOLD: begin
          sdo_q <= 1'b0;
          if (half_last_d) begin
            half_q     <= '0;
            cs_q       <= 1'b1;
            rx_data_q  <= rx_q;
            rx_valid_q <= 1'b1;
            state_q    <= ST_GAP;
          end else begin
            half_q <= half_inc_d;
          end
        end

        ST_GAP: begin
          // Guarantees the minimum chip-select high time between frames.
          if (half_last_d) begin
            half_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            half_q <= half_inc_d;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          cs_q    <= 1'b1;
          sck_q   <= 1'b0;
          sdo_q   <= 1'b0;
          half_q  <= '0;
          bit_q   <= '0;
        end
      endcase
    end
  end

  assign tx_ready_o = ready_q;
  assign busy_o     = busy_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign spi_cs_o   = cs_q;
  assign spi_sck_o  = sck_q;
  assign spi_sdo_o  = sdo_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_pixel_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_pixel_master
// Purpose  : Self-checking bench for spi_pixel_master. A default build is
//            connected to a behavioural SPI slave or looped back. A second
//            build with CLK_DIV=2 is always looped back.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_pixel_master;
  localparam int PW  = 24;
  localparam int CD  = 4;
  localparam int CD2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          tx_valid, tx_ready, rx_valid, busy, cs, sck, sdo, sdi;
  logic [PW-1:0] tx_data, rx_data;
  logic          tx_valid2, tx_ready2, rx_valid2, busy2, cs2, sck2, sdo2;
  logic [PW-1:0] tx_data2, rx_data2;

  logic          lb;
  logic          miso;
  logic [PW-1:0] sl_word, sl_out, sl_cap;

  assign sdi = lb ? sdo : miso;

  spi_pixel_master #(.PIXEL_WIDTH(PW), .CLK_DIV(CD)) dut (
    .clk_i(clk), .reset_i(rst), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .tx_data_i(tx_data), .rx_valid_o(rx_valid), .rx_data_o(rx_data),
    .busy_o(busy), .spi_cs_o(cs), .spi_sck_o(sck), .spi_sdo_o(sdo),
    .spi_sdi_i(sdi)
  );

  spi_pixel_master #(.PIXEL_WIDTH(PW), .CLK_DIV(CD2)) dut2 (
    .clk_i(clk), .reset_i(rst), .tx_valid_i(tx_valid2), .tx_ready_o(tx_ready2),
    .tx_data_i(tx_data2), .rx_valid_o(rx_valid2), .rx_data_o(rx_data2),
    .busy_o(busy2), .spi_cs_o(cs2), .spi_sck_o(sck2), .spi_sdo_o(sdo2),
    .spi_sdi_i(sdo2)
  );

  // Behavioural mode-0 slave: MSB valid at CS fall, MISO changes on SCK
  // fall, MOSI captured on SCK rise.
  initial begin
    miso   = 1'b0;
    sl_out = '0;
    sl_cap = '0;
  end
  always @(negedge cs) begin
    sl_out = sl_word;
    miso   = sl_word[PW-1];
    sl_cap = '0;
  end
  always @(posedge sck) if (!cs) sl_cap = {sl_cap[PW-2:0], sdo};
  always @(negedge sck) if (!cs) begin
    sl_out = {sl_out[PW-2:0], 1'b0};
    miso   = sl_out[PW-1];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Sends one word on the default build and observes the whole frame.
  task automatic send_frame(input logic [PW-1:0] word, input bit use_lb,
                            input logic [PW-1:0] sw, input int inject_at,
                            output logic [PW-1:0] got, output int cs_low,
                            output int rises, output int pulses, output int busy_err);
    int  g;
    bit  prev;
    bit  done;
    got = '0; cs_low = 0; rises = 0; pulses = 0; busy_err = 0;
    prev = 1'b0; done = 1'b0;
    lb = use_lb;
    sl_word = sw;
    g = 0;
    while (!tx_ready && g < 2000) begin @(negedge clk); g++; end
    check("ready_before_send", tx_ready, 1);
    tx_data = word; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = '0;
    for (int n = 0; n < 2000 && !done; n++) begin
      if (!cs) cs_low++;
      if (sck && !prev) rises++;
      prev = sck;
      if (!cs && (tx_ready || !busy)) busy_err++;
      if (rx_valid) begin pulses++; got = rx_data; end
      if (inject_at >= 0 && n == inject_at) begin
        check("reject_ready_low", tx_ready, 0);
        tx_data = 24'hDEAD00; tx_valid = 1'b1;
      end else if (inject_at >= 0 && n == inject_at + 1) begin
        tx_valid = 1'b0; tx_data = '0;
      end
      if (pulses > 0 && tx_ready) done = 1'b1;
      else @(negedge clk);
    end
    check("frame_done", done, 1);
  endtask

  typedef struct {
    logic [PW-1:0] tx;
    bit            lb;
    logic [PW-1:0] sw;
    logic [PW-1:0] exp_rx;
    logic [PW-1:0] exp_cap;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [PW-1:0] got, tx, sw, exp_rx;
    int            cs_low, rises, pulses, busy_err, n_low;
    bit            rlb;
    int            pt[2];
    logic [PW-1:0] pv[2];
    int            cyc, csh, accepts;
    bit            started2, drop_valid;
    int            hi_run, lo_run, run_err;
    bit            prev, seen_rise, done;

    vecs[0] = '{tx: 24'hA5C33C, lb: 1'b1, sw: 24'h000000, exp_rx: 24'hA5C33C, exp_cap: 24'hA5C33C};
    vecs[1] = '{tx: 24'hFFFFFF, lb: 1'b0, sw: 24'h123456, exp_rx: 24'h123456, exp_cap: 24'hFFFFFF};
    vecs[2] = '{tx: 24'h000000, lb: 1'b0, sw: 24'hFFFFFF, exp_rx: 24'hFFFFFF, exp_cap: 24'h000000};
    vecs[3] = '{tx: 24'h800001, lb: 1'b0, sw: 24'h000000, exp_rx: 24'h000000, exp_cap: 24'h800001};

    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_valid2 = 1'b0; tx_data2 = '0;
    lb = 1'b1; sl_word = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state of both builds.
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_sdo", sdo, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst2_cs", cs2, 1);
    check("rst2_ready", tx_ready2, 1);

    // Directed vectors.
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].tx, vecs[i].lb, vecs[i].sw, -1, got, cs_low, rises, pulses, busy_err);
      check("vec_rx", got, vecs[i].exp_rx);
      check("vec_rx_hold", rx_data, vecs[i].exp_rx);
      check("vec_slave_cap", sl_cap, vecs[i].exp_cap);
      check("vec_cs_low", cs_low, CD * (2 * PW + 2));
      check("vec_rises", rises, PW);
      check("vec_pulses", pulses, 1);
      check("vec_busy", busy_err, 0);
    end

    // Randomised frames against the reference model: the master returns what
    // the slave (or loopback) sent and the slave receives the master word.
    for (int i = 0; i < 8; i++) begin
      tx  = PW'($urandom());
      sw  = PW'($urandom());
      rlb = 1'($urandom_range(0, 1));
      exp_rx = rlb ? tx : sw;
      send_frame(tx, rlb, sw, -1, got, cs_low, rises, pulses, busy_err);
      check("rand_rx", got, exp_rx);
      check("rand_slave_cap", sl_cap, tx);
      check("rand_cs_low", cs_low, CD * (2 * PW + 2));
      check("rand_pulses", pulses, 1);
    end

    // Back-to-back with tx_valid held high.
    lb = 1'b1;
    tx_data = 24'h000001; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 24'h800000;
    cyc = 0; csh = 0; accepts = 1; started2 = 1'b0; drop_valid = 1'b0;
    pt[0] = 0; pt[1] = 0; pv[0] = '0; pv[1] = '0;
    begin
      int np;
      np = 0;
      for (int n = 0; n < 1000 && np < 2; n++) begin
        cyc++;
        if (accepts == 1 && tx_ready && tx_valid) begin accepts = 2; drop_valid = 1'b1; end
        if (rx_valid) begin pt[np] = cyc; pv[np] = rx_data; np++; end
        if (np == 1 && cs && !started2) csh++;
        if (np == 1 && !cs) started2 = 1'b1;
        if (np < 2) begin
          @(negedge clk);
          if (drop_valid) begin tx_valid = 1'b0; tx_data = '0; drop_valid = 1'b0; end
        end
      end
      check("b2b_pulses", np, 2);
    end
    tx_valid = 1'b0;
    check("b2b_rx0", pv[0], 24'h000001);
    check("b2b_rx1", pv[1], 24'h800000);
    check("b2b_cs_high", csh, CD + 1);
    check("b2b_period", pt[1] - pt[0], CD * (2 * PW + 3) + 1);

    // Busy rejection: a word offered mid-frame is dropped.
    send_frame(24'h0F0F0F, 1'b1, 24'h0, 60, got, cs_low, rises, pulses, busy_err);
    check("busy_rx", got, 24'h0F0F0F);
    check("busy_cs_low", cs_low, CD * (2 * PW + 2));
    check("busy_pulses", pulses, 1);
    n_low = 0;
    for (int n = 0; n < 30; n++) begin
      if (!cs) n_low++;
      @(negedge clk);
    end
    check("busy_no_extra_frame", n_low, 0);

    // Mid-frame reset after the 10th rising edge.
    lb = 1'b1;
    tx_data = 24'hFFFFFF; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    rises = 0; prev = 1'b0;
    for (int n = 0; n < 2000 && rises < 10; n++) begin
      if (sck && !prev) rises++;
      prev = sck;
      if (rises < 10) @(negedge clk);
    end
    check("mrst_rises", rises, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_cs", cs, 1);
    check("mrst_sck", sck, 0);
    check("mrst_rx_data", rx_data, 0);
    check("mrst_ready", tx_ready, 1);
    check("mrst_busy", busy, 0);
    check("mrst_rx_valid", rx_valid, 0);
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      if (rx_valid) pulses++;
      @(negedge clk);
    end
    check("mrst_no_pulse", pulses, 0);
    send_frame(24'h5A5A5A, 1'b1, 24'h0, -1, got, cs_low, rises, pulses, busy_err);
    check("mrst_resend_rx", got, 24'h5A5A5A);

    // CLK_DIV=2 build, loopback.
    tx_data2 = 24'hC0FFEE; tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0;
    cs_low = 0; rises = 0; pulses = 0; got = '0;
    hi_run = 0; lo_run = 0; run_err = 0; prev = 1'b0; seen_rise = 1'b0; done = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
      if (!cs2) cs_low++;
      if (sck2) begin
        if (!prev) begin
          rises++;
          if (seen_rise && lo_run != CD2) run_err++;
          seen_rise = 1'b1;
        end
        hi_run++;
      end else begin
        if (prev) begin
          if (hi_run != CD2) run_err++;
          hi_run = 0;
          lo_run = 0;
        end
        lo_run++;
      end
      prev = sck2;
      if (rx_valid2) begin pulses++; got = rx_data2; end
      if (pulses > 0 && tx_ready2) done = 1'b1;
      else @(negedge clk);
    end
    check("div2_done", done, 1);
    check("div2_rx", got, 24'hC0FFEE);
    check("div2_cs_low", cs_low, CD2 * (2 * PW + 2));
    check("div2_rises", rises, PW);
    check("div2_sck_runs", run_err, 0);
    check("div2_pulses", pulses, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
